// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                               |
// | Purpose  : Shared constants for the two-requester line-memory        |
// |            arbiter: FSM state encoding, requester IDs, default line  |
// |            width and the post-ISSUE state selection helper.          |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

   // Arbiter FSM state encoding
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT_RD = 2'd2;
   localparam logic [1:0] WAIT_WR = 2'd3;

   // Requester identifiers
   localparam logic REQ_I = 1'b0;   // instruction cache
   localparam logic REQ_D = 1'b1;   // data cache

   // Default line geometry
   localparam int DEFAULT_LINE_SIZE = 16;
   localparam int LINE_BITS         = DEFAULT_LINE_SIZE * 8;

   // State entered once memory accepts the issued request.
   function automatic logic [1:0] wait_state_for(input logic is_write);
      return is_write ? WAIT_WR : WAIT_RD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter2                                               |
// | Purpose  : Combinational two-way round-robin arbiter. A lone request |
// |            wins outright; on a tie the requester that did not win    |
// |            last time is chosen.                                      |
// | Ports    : req0, req1   - qualified requests                         |
// |            last_grant   - ID of the previous winner                  |
// |            gnt_valid    - some request is granted                    |
// |            gnt_id       - ID of the granted requester                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = REQ_I;
      if (req0 && req1) begin
         gnt_id = ~last_grant;
      end else if (req1) begin
         gnt_id = REQ_D;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_arbiter                                               |
// | Purpose  : Shares one line-wide memory port between the I-cache (r0) |
// |            and D-cache (r1). One transaction at a time; responses    |
// |            are routed back to the requester that was granted.        |
// | Ports    : clk, reset (sync, active low)                             |
// |            rN_valid/addr/read/write/din  - requester N request       |
// |            rN_ack                        - request accepted (comb.)  |
// |            rN_resp_valid, resp_data      - completion pulse / data   |
// |            mem_is_input_valid/addr/read/write/din - memory request   |
// |            mem_ready, mem_output_valid, mem_dout  - memory handshake |
// |            busy                          - FSM not idle              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LINE_SIZE = DEFAULT_LINE_SIZE,
   parameter int ADDR_W    = 32
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   r0_valid,
   input  logic [ADDR_W-1:0]      r0_addr,
   input  logic                   r0_read,
   input  logic                   r0_write,
   input  logic [LINE_SIZE*8-1:0] r0_din,
   input  logic                   r1_valid,
   input  logic [ADDR_W-1:0]      r1_addr,
   input  logic                   r1_read,
   input  logic                   r1_write,
   input  logic [LINE_SIZE*8-1:0] r1_din,
   output logic                   r0_ack,
   output logic                   r1_ack,
   output logic                   r0_resp_valid,
   output logic                   r1_resp_valid,
   output logic [LINE_SIZE*8-1:0] resp_data,
   output logic                   mem_is_input_valid,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [LINE_SIZE*8-1:0] mem_din,
   input  logic                   mem_ready,
   input  logic                   mem_output_valid,
   input  logic [LINE_SIZE*8-1:0] mem_dout,
   output logic                   busy
);

   localparam int DATA_W = LINE_SIZE * 8;

   logic [1:0]        state_q,      state_d;
   logic              last_grant_q, last_grant_d;
   logic              cur_id_q,     cur_id_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic              wr_q,         wr_d;
   logic [DATA_W-1:0] din_q,        din_d;
   logic [DATA_W-1:0] resp_data_q,  resp_data_d;
   logic              resp0_q,      resp0_d;
   logic              resp1_q,      resp1_d;

   logic req0;
   logic req1;
   logic gnt_valid;
   logic gnt_id;
   logic ack_en;
   logic in_issue;

   // A valid with neither read nor write is not a real request.
   assign req0 = r0_valid & (r0_read | r0_write);
   assign req1 = r1_valid & (r1_read | r1_write);

   rr_arbiter2 u_rr_arbiter2 (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   // Gated by reset so no requester sees an ack while the block is held.
   assign ack_en   = reset & (state_q == IDLE) & gnt_valid;
   assign r0_ack   = ack_en & (gnt_id == REQ_I);
   assign r1_ack   = ack_en & (gnt_id == REQ_D);
   assign in_issue = (state_q == ISSUE);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_id_d     = cur_id_q;
      addr_d       = addr_q;
      wr_d         = wr_q;
      din_d        = din_q;
      resp_data_d  = resp_data_q;
      resp0_d      = 1'b0;
      resp1_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (ack_en) begin
               cur_id_d     = gnt_id;
               last_grant_d = gnt_id;
               // Write wins when both read and write are set.
               if (gnt_id == REQ_D) begin
                  addr_d = r1_addr;
                  wr_d   = r1_write;
                  din_d  = r1_din;
               end else begin
                  addr_d = r0_addr;
                  wr_d   = r0_write;
                  din_d  = r0_din;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_ready) begin
               state_d = wait_state_for(wr_q);
            end
         end
         WAIT_RD: begin
            if (mem_output_valid) begin
               resp_data_d = mem_dout;
               resp0_d     = (cur_id_q == REQ_I);
               resp1_d     = (cur_id_q == REQ_D);
               state_d     = IDLE;
            end
         end
         WAIT_WR: begin
            // The write is done on the first ready edge after acceptance.
            if (mem_ready) begin
               resp0_d = (cur_id_q == REQ_I);
               resp1_d = (cur_id_q == REQ_D);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_D;   // r0 wins the first tie
         cur_id_q     <= REQ_I;
         addr_q       <= '0;
         wr_q         <= 1'b0;
         din_q        <= '0;
         resp_data_q  <= '0;
         resp0_q      <= 1'b0;
         resp1_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cur_id_q     <= cur_id_d;
         addr_q       <= addr_d;
         wr_q         <= wr_d;
         din_q        <= din_d;
         resp_data_q  <= resp_data_d;
         resp0_q      <= resp0_d;
         resp1_q      <= resp1_d;
      end
   end

   // Memory request fields are forced to zero outside ISSUE.
   assign mem_is_input_valid = in_issue;
   assign mem_addr           = in_issue ? addr_q : '0;
   assign mem_read           = in_issue & ~wr_q;
   assign mem_write          = in_issue & wr_q;
   assign mem_din            = in_issue ? din_q : '0;

   assign r0_resp_valid = resp0_q;
   assign r1_resp_valid = resp1_q;
   assign resp_data     = resp_data_q;
   assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single line-wide data memory port between two cache requesters: requester 0 is the I-cache and requester 1 is the D-cache.
- Sits between the caches and the data memory. It accepts one line transaction at a time and drives the memory handshake (is_input_valid / mem_ready / is_output_valid).
- It routes the response back to the granted requester.
- Ties between simultaneous requests are broken round-robin.

Parameters:
- LINE_SIZE, default 16: line size in bytes. Data buses are LINE_SIZE*8 bits wide.
- ADDR_W, default 32: address width in bits.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- reset  input  1  Synchronous, active-low reset: asserted when 0, sampled on the rising edge of clk.
- r0_valid / r1_valid  input  1  Request pending. Held high by the requester until its ack.
- r0_addr / r1_addr  input  ADDR_W  Line-aligned request address.
- r0_read / r1_read  input  1  Read (fill) request.
- r0_write / r1_write  input  1  Write (writeback) request.
- r0_din / r1_din  input  LINE_SIZE*8  Writeback line data.
- r0_ack / r1_ack  output  1  Request accepted this cycle.
- r0_resp_valid / r1_resp_valid  output  1  One-cycle completion pulse.
- resp_data  output  LINE_SIZE*8  Read line data. Valid with the respective resp_valid pulse.
- mem_is_input_valid  output  1  Request valid to the memory.
- mem_addr  output  ADDR_W  Memory address.
- mem_read  output  1  Memory read.
- mem_write  output  1  Memory write.
- mem_din  output  LINE_SIZE*8  Memory write data.
- mem_ready  input  1  Memory can accept a request.
- mem_output_valid  input  1  Memory read data valid.
- mem_dout  input  LINE_SIZE*8  Memory read data.
- busy  output  1  High in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR. Registers:
  - last_grant, 1 bit
  - cur_id, 1 bit
  - latched addr, rw and din
- Reset (reset==0 at an edge):
  - state goes to IDLE and last_grant to 1, so r0 wins the first tie.
  - All outputs are 0 and resp_data is 0.
  - Reset mid-transaction abandons it silently: no resp_valid is pulsed.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester that is not last_grant.
  - rN_ack is combinational: (state==IDLE) && grant==N. At most one ack is high per cycle.
  - On the ack edge: latch addr, read/write and din; set cur_id and last_grant to N; go to ISSUE.
  - If a request has both read and write high, it is treated as a write.
  - A request with valid=1 and neither read nor write high is not acked.
- ISSUE:
  - mem_is_input_valid=1, driving the latched addr, read/write and din.
  - Waits while mem_ready==0.
  - When mem_ready==1 at an edge: go to WAIT_RD (read) or WAIT_WR (write). mem_is_input_valid drops the next cycle.
- WAIT_RD:
  - When mem_output_valid==1 at an edge: capture mem_dout into resp_data, pulse r{cur_id}_resp_valid in the next cycle, go to IDLE.
- WAIT_WR:
  - The write is complete on the first edge where mem_ready==1 (at least one cycle after acceptance).
  - On completion: pulse r{cur_id}_resp_valid in the next cycle, leave resp_data unchanged, go to IDLE.
- The resp_valid pulse cycle is also an IDLE cycle, so a new ack can occur in that same cycle (back-to-back).
- mem_output_valid in any state other than WAIT_RD is ignored.
- Requester inputs outside the ack cycle are ignored. Changing addr after ack has no effect.
- Minimum read latency, with the ack at cycle T:
  - ISSUE at T+1
  - WAIT_RD at T+2
  - if mem_output_valid is high at T+2, resp_valid at T+3.
- With both requesters continuously valid, grants strictly alternate: 0, 1, 0, 1, ...
- mem_read, mem_write, mem_addr and mem_din are 0 outside ISSUE.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding: IDLE=0, ISSUE=1, WAIT_RD=2, WAIT_WR=3
  - requester IDs: REQ_I=0, REQ_D=1
  - LINE_BITS constant.
- Sub-module rr_arbiter2 is combinational: (req0, req1, last_grant) -> (gnt_valid, gnt_id).

Test Plan:
- Reset: reset=0 for 2 cycles with both valids high -> no ack, busy=0, all mem outputs 0. After release, r0 is acked first.
- Single read: r1 reads addr 0x0000_0040, mem_ready=1, mem_output_valid 3 cycles after acceptance with dout=128'hA5...A5 -> r1_resp_valid pulses once with resp_data=128'hA5...A5; r0 gets no pulse.
- Write: r0 writes addr 0x100, din=128'h1234..., mem_ready held low for 2 cycles after ISSUE -> mem_write=1 and mem_din=128'h1234... until accepted; r0_resp_valid pulses once mem_ready returns high.
- Contention: both requesters valid continuously for 4 transactions -> ack order 0,1,0,1; mem_addr matches each granted requester's address.
- Stall and spurious data: mem_output_valid pulsed while in ISSUE -> ignored; the response carries data from the later pulse in WAIT_RD.
- Mid-op reset: reset=0 during WAIT_RD -> returns to IDLE, no resp_valid; the next request completes normally.
